uart_rx: RTL

- 8N1 UART receiver. It is the downstream stage of the team's uart_tx: it deserialises the tx serial line back into bytes.
- It oversamples the line at CLKS_PER_BIT system clocks per bit and samples each bit at mid-bit.
- Each received byte is presented on a valid/ready output interface, with framing-error and overrun flags.
- Bit order is LSB first: start bit 0, 8 data bits, stop bit 1, matching uart_tx.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
//   DATA_BITS        - payload bits per frame (8N1 framing).
//   uart_rx_state_t  - receiver state encoding. uart_tx is expected to share
//                      this package for its own state type.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte output channel of the UART receiver.
//   data       - received byte, stable while valid is high
//   valid      - data holds an unconsumed byte
//   ready      - consumer accepts data on a valid&&ready cycle
//   frame_err  - one-cycle pulse, stop bit sampled low
//   overrun    - one-cycle pulse, good byte dropped because holding reg was full
// master: the receiver side. slave: the consumer side.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data,
    output valid,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for a single asynchronous input.
//   clk       - destination clock
//   rst_n     - asynchronous active-low reset; both flops load RESET_VAL
//   d         - asynchronous input
//   q         - synchronised output, two clk cycles of latency
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, oversampled at CLKS_PER_BIT.
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   rx     - serial line, asynchronous, idles high
//   out    - byte channel (uart_rx_if.master): data/valid/ready plus
//            frame_err and overrun pulses
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line high, waiting for a falling edge on rx_s
// START     | timing to mid start bit to confirm it is not a glitch
// DATA      | sampling 8 data bits at mid-bit, LSB first
// STOP      | timing to mid stop bit; high = good byte, low = frame error
// WAIT_HIGH | after a frame error, wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  uart_rx_if.master  out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
  end

  logic rx_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_rx_state_t       state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 stop_good, stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  // Timing is measured from the synchronised start edge only; the first
  // sample lands half a bit in, every later one a full bit after that.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_MID) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (state == STOP && cnt == CNT_LAST) begin
      stop_good = rx_s;
      stop_bad  = !rx_s;
    end
  end

  // Holding register loads on the same edge the FSM leaves STOP. A byte
  // arriving while the old one is being handed off replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.data      <= '0;
      out.valid     <= 1'b0;
      out.frame_err <= 1'b0;
      out.overrun   <= 1'b0;
    end else begin
      out.frame_err <= stop_bad;
      out.overrun   <= 1'b0;
      if (stop_good) begin
        if (!out.valid || out.ready) begin
          out.data  <= shift;
          out.valid <= 1'b1;
        end else begin
          out.overrun <= 1'b1;
        end
      end else if (out.valid && out.ready) begin
        out.valid <= 1'b0;
      end
    end
  end

endmodule
